// File: rtl/fe_mul_arbiter_pkg.sv
// rtl/fe_mul_arbiter_pkg.sv - shared types and constants for the field-multiplier arbiter
package fe_mul_arbiter_pkg;

    localparam int FE_W = 320;
    localparam logic [FE_W-1:0] FE_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fe_mul_arbiter_if.sv
// rtl/fe_mul_arbiter_if.sv - requester and multiplier buses of the field-multiplier arbiter
interface fe_mul_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 320
);
    logic [NREQ*W-1:0] req_op_a;
    logic [NREQ*W-1:0] req_op_b;
    logic [NREQ-1:0]   req_valid;
    logic [W-1:0]      req_res;
    logic [NREQ-1:0]   req_done;
    logic [W-1:0]      mul_op_a;
    logic [W-1:0]      mul_op_b;
    logic              mul_valid;
    logic [W-1:0]      mul_res;
    logic              mul_done;

    modport slave (
        input  req_op_a, req_op_b, req_valid, mul_res, mul_done,
        output req_res, req_done, mul_op_a, mul_op_b, mul_valid
    );

    modport master (
        output req_op_a, req_op_b, req_valid, mul_res, mul_done,
        input  req_res, req_done, mul_op_a, mul_op_b, mul_valid
    );

endinterface

// File: rtl/fe_mul_arbiter_rr_pick.sv
// rtl/fe_mul_arbiter_rr_pick.sv - combinational round-robin pick starting at i_rr_ptr
module fe_mul_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_pending,
    input  logic [IW-1:0]   i_rr_ptr,
    output logic [IW-1:0]   o_grant,
    output logic            o_any
);

    logic [IW-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = IW'((int'(i_rr_ptr) + k) % NREQ);
            if (!o_any && i_pending[w_idx]) begin
                o_any   = 1'b1;
                o_grant = w_idx;
            end
        end
    end

endmodule

// File: rtl/fe_mul_arbiter.sv
// rtl/fe_mul_arbiter.sv - round-robin sharing of one field multiplier among NREQ requesters
module fe_mul_arbiter
    import fe_mul_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = FE_W,
    parameter int TIMEOUT = 64
) (
    input  logic                i_clk,
    input  logic                i_rst,
    fe_mul_arbiter_if.slave     bus,
    output logic                o_timeout_err,
    output logic                o_overrun_err
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT) + 1;

    state_t          r_state;
    logic [NREQ-1:0] r_pending;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   r_grant;
    logic [CW-1:0]   r_wait_cnt;
    logic [W-1:0]    r_req_res;
    logic [NREQ-1:0] r_req_done;
    logic [W-1:0]    r_mul_op_a;
    logic [W-1:0]    r_mul_op_b;
    logic            r_mul_valid;
    logic            r_timeout_err;
    logic            r_overrun_err;

    logic [IW-1:0]   w_pick;
    logic            w_any;
    logic [NREQ-1:0] w_clr;
    logic [NREQ-1:0] w_overrun;
    logic [NREQ-1:0] w_grant_oh;
    logic [W-1:0]    w_op_a;
    logic [W-1:0]    w_op_b;

    fe_mul_arbiter_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .i_pending (r_pending),
        .i_rr_ptr  (r_rr_ptr),
        .o_grant   (w_pick),
        .o_any     (w_any)
    );

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_pick == IW'(k)) begin
                w_op_a = bus.req_op_a[k*W +: W];
                w_op_b = bus.req_op_b[k*W +: W];
            end
        end
    end

    always_comb begin
        w_clr = '0;
        if (r_state == ST_DONE) begin
            w_clr[r_grant] = 1'b1;
        end
    end

    // A new pulse in the completion cycle re-arms the requester rather than overrunning.
    assign w_overrun  = bus.req_valid & r_pending & ~w_clr;
    assign w_grant_oh = NREQ'(1) << r_grant;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_pending     <= '0;
            r_rr_ptr      <= '0;
            r_grant       <= '0;
            r_wait_cnt    <= '0;
            r_req_res     <= '0;
            r_req_done    <= '0;
            r_mul_op_a    <= '0;
            r_mul_op_b    <= '0;
            r_mul_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_pending   <= (r_pending & ~w_clr) | bus.req_valid;
            r_mul_valid <= 1'b0;
            r_req_done  <= '0;
            if (|w_overrun) begin
                r_overrun_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant     <= w_pick;
                        r_mul_op_a  <= w_op_a;
                        r_mul_op_b  <= w_op_b;
                        r_mul_valid <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (bus.mul_done) begin
                        r_req_res  <= bus.mul_res;
                        r_req_done <= w_grant_oh;
                        r_state    <= ST_DONE;
                    end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_req_res     <= '0;
                        r_req_done    <= w_grant_oh;
                        r_state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_rr_ptr <= (r_grant == IW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_res    = r_req_res;
    assign bus.req_done   = r_req_done;
    assign bus.mul_op_a   = r_mul_op_a;
    assign bus.mul_op_b   = r_mul_op_b;
    assign bus.mul_valid  = r_mul_valid;
    assign o_timeout_err  = r_timeout_err;
    assign o_overrun_err  = r_overrun_err;

endmodule

// File: tb/tb_fe_mul_arbiter.sv
// tb/tb_fe_mul_arbiter.sv - randomized self-checking bench for fe_mul_arbiter with a latency-programmable multiplier stub
module tb_fe_mul_arbiter;

    localparam int N  = 4;
    localparam int FW = 320;
    localparam int TO = 64;

    typedef struct {
        int             c;
        logic [N-1:0]   d;
        logic [FW-1:0]  r;
    } ev_t;

    logic clk;
    logic rst;
    logic timeout_err;
    logic overrun_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    ev_t dn_q[$];
    int  mv_q[$];

    logic [FW-1:0] opa [N];
    logic [FW-1:0] opb [N];

    int            stub_l   = 8;
    int            stub_cnt = 0;
    logic [FW-1:0] stub_p;

    fe_mul_arbiter_if #(.NREQ(N), .W(FW)) bus ();

    fe_mul_arbiter #(.NREQ(N), .W(FW), .TIMEOUT(TO)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .bus           (bus),
        .o_timeout_err (timeout_err),
        .o_overrun_err (overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stub: done exactly stub_l cycles after the cycle mul_valid is high.
    always @(posedge clk) begin
        bus.mul_done <= 1'b0;
        if (bus.mul_valid) begin
            stub_cnt <= stub_l - 1;
            stub_p   <= bus.mul_op_a * bus.mul_op_b;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                bus.mul_done <= 1'b1;
                bus.mul_res  <= stub_p;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.mul_valid) mv_q.push_back(cyc);
        if (bus.req_done != '0) dn_q.push_back('{cyc, bus.req_done, bus.req_res});
    end

    function automatic logic [FW-1:0] mul320(input logic [FW-1:0] a, input logic [FW-1:0] b);
        return a * b;
    endfunction

    function automatic logic [FW-1:0] rnd320();
        logic [FW-1:0] v;
        for (int k = 0; k < FW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [FW-1:0] a, input logic [FW-1:0] b);
        opa[i] = a;
        opb[i] = b;
        bus.req_op_a[i*FW +: FW] = a;
        bus.req_op_b[i*FW +: FW] = b;
    endtask

    task automatic pulse(input logic [N-1:0] v);
        bus.req_valid = v;
        tick();
        bus.req_valid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        mv_q.delete();
        dn_q.delete();
    endtask

    task automatic wait_done(input int n, input int bound);
        int k = 0;
        while (dn_q.size() < n && k < bound) begin
            tick();
            k++;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        for (int i = 0; i < N; i++) set_ops(i, '0, '0);
        tick();
        tick();
        n_tests++; if (bus.req_done !== '0) begin n_fail++; $display("FAIL reset_req_done: got %b want 0", bus.req_done); end
        n_tests++; if (bus.req_res !== '0) begin n_fail++; $display("FAIL reset_req_res: got %h want 0", bus.req_res); end
        n_tests++; if (bus.mul_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mul_valid: got %b want 0", bus.mul_valid); end
        n_tests++; if (bus.mul_op_a !== '0) begin n_fail++; $display("FAIL reset_mul_op_a: got %h want 0", bus.mul_op_a); end
        n_tests++; if (bus.mul_op_b !== '0) begin n_fail++; $display("FAIL reset_mul_op_b: got %h want 0", bus.mul_op_b); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        n_tests++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL reset_overrun_err: got %b want 0", overrun_err); end
        rst = 1'b0;
        mv_q.delete();
        dn_q.delete();
        repeat (5) tick();
        n_tests++; if (mv_q.size() != 0) begin n_fail++; $display("FAIL reset_idle_no_issue: got %0d issues want 0", mv_q.size()); end
    endtask

    task automatic test_single();
        int t0;
        do_reset();
        stub_l = 8;
        set_ops(1, 320'd2, 320'd3);
        t0 = cyc;
        pulse(4'b0010);
        wait_done(1, 40);
        repeat (4) tick();
        n_tests++; if (mv_q.size() != 1) begin n_fail++; $display("FAIL single_issue_count: got %0d want 1", mv_q.size()); end
        if (mv_q.size() > 0) begin
            n_tests++; if (mv_q[0] != t0 + 2) begin n_fail++; $display("FAIL single_mul_valid_cyc: got %0d want %0d", mv_q[0] - t0, 2); end
        end
        n_tests++; if (dn_q.size() != 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", dn_q.size()); end
        if (dn_q.size() > 0) begin
            n_tests++; if (dn_q[0].c != t0 + 11) begin n_fail++; $display("FAIL single_done_cyc: got %0d want 11", dn_q[0].c - t0); end
            n_tests++; if (dn_q[0].d !== 4'b0010) begin n_fail++; $display("FAIL single_done_onehot: got %b want 0010", dn_q[0].d); end
            n_tests++; if (dn_q[0].r !== 320'd6) begin n_fail++; $display("FAIL single_res: got %0d want 6", dn_q[0].r); end
        end
        n_tests++; if (bus.mul_op_a !== 320'd2 || bus.mul_op_b !== 320'd3) begin n_fail++; $display("FAIL single_mul_ops: got %0d,%0d want 2,3", bus.mul_op_a, bus.mul_op_b); end
    endtask

    task automatic test_all_four();
        int t0;
        int l;
        do_reset();
        l = $urandom_range(2, 10);
        stub_l = l;
        for (int i = 0; i < N; i++) set_ops(i, FW'(i + 1), 320'd10);
        t0 = cyc;
        pulse(4'b1111);
        wait_done(4, 4 * (l + 3) + 20);
        n_tests++; if (dn_q.size() != 4) begin n_fail++; $display("FAIL all4_done_count: got %0d want 4", dn_q.size()); end
        for (int i = 0; i < N && i < dn_q.size(); i++) begin
            n_tests++;
            if (dn_q[i].d !== N'(1 << i) || dn_q[i].r !== FW'(10 * (i + 1)) || dn_q[i].c != t0 + l + 3 + i * (l + 3)) begin
                n_fail++;
                $display("FAIL all4_done_%0d: got d=%b r=%0d c=%0d want d=%b r=%0d c=%0d", i, dn_q[i].d, dn_q[i].r,
                         dn_q[i].c - t0, N'(1 << i), 10 * (i + 1), l + 3 + i * (l + 3));
            end
        end
    endtask

    task automatic test_rr_wrap();
        int t0;
        int exp_g [3];
        exp_g = '{2, 3, 0};
        do_reset();
        stub_l = 6;
        for (int i = 0; i < N; i++) set_ops(i, rnd320(), rnd320());
        t0 = cyc;
        pulse(4'b0100);
        wait_until(t0 + 4);
        pulse(4'b1000);
        wait_until(t0 + 6);
        pulse(4'b0001);
        wait_done(3, 60);
        n_tests++; if (dn_q.size() != 3) begin n_fail++; $display("FAIL rr_done_count: got %0d want 3", dn_q.size()); end
        for (int i = 0; i < 3 && i < dn_q.size(); i++) begin
            n_tests++;
            if (dn_q[i].d !== N'(1 << exp_g[i]) || dn_q[i].r !== mul320(opa[exp_g[i]], opb[exp_g[i]]) || dn_q[i].c != t0 + 9 + 9 * i) begin
                n_fail++;
                $display("FAIL rr_order_%0d: got d=%b c=%0d want d=%b c=%0d", i, dn_q[i].d, dn_q[i].c - t0, N'(1 << exp_g[i]), 9 + 9 * i);
            end
        end
    endtask

    task automatic test_timeout();
        int t0;
        do_reset();
        stub_l = TO;
        set_ops(0, rnd320(), rnd320());
        t0 = cyc;
        pulse(4'b0001);
        wait_done(1, 100);
        n_tests++; if (dn_q.size() != 1) begin n_fail++; $display("FAIL tmo_edge_count: got %0d want 1", dn_q.size()); end
        if (dn_q.size() > 0) begin
            n_tests++; if (dn_q[0].c != t0 + 67 || dn_q[0].r !== mul320(opa[0], opb[0])) begin n_fail++; $display("FAIL tmo_edge_done: got c=%0d r=%h want c=67 product", dn_q[0].c - t0, dn_q[0].r); end
        end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_edge_err: got %b want 0", timeout_err); end

        do_reset();
        stub_l = 100;
        set_ops(0, rnd320(), rnd320());
        t0 = cyc;
        pulse(4'b0001);
        wait_done(1, 100);
        n_tests++; if (dn_q.size() != 1) begin n_fail++; $display("FAIL tmo_count: got %0d want 1", dn_q.size()); end
        if (dn_q.size() > 0) begin
            n_tests++; if (dn_q[0].c != t0 + 67 || dn_q[0].d !== 4'b0001 || dn_q[0].r !== '0) begin n_fail++; $display("FAIL tmo_done: got c=%0d d=%b r=%h want c=67 d=0001 r=0", dn_q[0].c - t0, dn_q[0].d, dn_q[0].r); end
        end
        n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err_set: got %b want 1", timeout_err); end
        wait_until(t0 + 115);
        n_tests++; if (dn_q.size() != 1 || mv_q.size() != 1) begin n_fail++; $display("FAIL tmo_late_done: got %0d dones %0d issues want 1 1", dn_q.size(), mv_q.size()); end
        n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err_sticky: got %b want 1", timeout_err); end
    endtask

    task automatic test_reset_mid();
        int t0;
        do_reset();
        stub_l = 4;
        set_ops(1, rnd320() | 320'd1, rnd320() | 320'd1);
        pulse(4'b0010);
        wait_done(1, 30);
        tick();
        stub_l = 20;
        set_ops(1, rnd320() | 320'd1, rnd320() | 320'd1);
        t0 = cyc;
        pulse(4'b0010);
        wait_until(t0 + 8);
        rst = 1'b1;
        tick();
        n_tests++; if (bus.req_res !== '0 || bus.req_done !== '0 || bus.mul_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs: got res=%h done=%b mv=%b want 0", bus.req_res, bus.req_done, bus.mul_valid); end
        n_tests++; if (bus.mul_op_a !== '0 || bus.mul_op_b !== '0) begin n_fail++; $display("FAIL rstmid_mul_ops: got %h %h want 0", bus.mul_op_a, bus.mul_op_b); end
        rst = 1'b0;
        mv_q.delete();
        dn_q.delete();
        wait_until(t0 + 35);
        n_tests++; if (dn_q.size() != 0 || mv_q.size() != 0) begin n_fail++; $display("FAIL rstmid_late_done: got %0d dones %0d issues want 0 0", dn_q.size(), mv_q.size()); end
        n_tests++; if (bus.req_res !== '0 || timeout_err !== 1'b0 || overrun_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got res=%h tmo=%b ovr=%b want 0", bus.req_res, timeout_err, overrun_err); end
    endtask

    task automatic test_overrun();
        int t0;
        int d1;
        do_reset();
        stub_l = 10;
        set_ops(2, rnd320(), rnd320());
        t0 = cyc;
        pulse(4'b0100);
        wait_until(t0 + 3);
        pulse(4'b0100);
        wait_done(1, 40);
        repeat (20) tick();
        n_tests++; if (overrun_err !== 1'b1) begin n_fail++; $display("FAIL ovr_err: got %b want 1", overrun_err); end
        n_tests++; if (dn_q.size() != 1 || mv_q.size() != 1) begin n_fail++; $display("FAIL ovr_single_done: got %0d dones %0d issues want 1 1", dn_q.size(), mv_q.size()); end

        do_reset();
        set_ops(2, rnd320(), rnd320());
        t0 = cyc;
        d1 = t0 + 13;
        pulse(4'b0100);
        wait_until(d1);
        n_tests++; if (bus.req_done !== 4'b0100) begin n_fail++; $display("FAIL b2b_first_done: got %b want 0100 at cycle 13", bus.req_done); end
        set_ops(2, rnd320(), rnd320());
        pulse(4'b0100);
        wait_done(2, 40);
        n_tests++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL b2b_ovr: got %b want 0", overrun_err); end
        n_tests++; if (dn_q.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", dn_q.size()); end
        if (dn_q.size() > 1) begin
            n_tests++; if (dn_q[1].c != d1 + 13 || dn_q[1].d !== 4'b0100 || dn_q[1].r !== mul320(opa[2], opb[2])) begin n_fail++; $display("FAIL b2b_second: got c=%0d d=%b want c=%0d d=0100", dn_q[1].c - t0, dn_q[1].d, 26); end
        end
    endtask

    task automatic test_random();
        int rt [N];
        int exp_c [N];
        int exp_g [N];
        int t0, l, nexp, cur, rr, mn, a, g;
        bit served [N];
        logic [N-1:0] v;
        for (int round = 0; round < 4; round++) begin
            do_reset();
            l = $urandom_range(2, 12);
            stub_l = l;
            nexp = 0;
            for (int i = 0; i < N; i++) begin
                rt[i] = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 12)) : -1;
                if (rt[i] >= 0) nexp++;
                served[i] = 1'b0;
                set_ops(i, rnd320(), rnd320());
            end
            t0 = cyc;
            for (int j = 0; j <= 12; j++) begin
                v = '0;
                for (int i = 0; i < N; i++) if (rt[i] == j) v[i] = 1'b1;
                bus.req_valid = v;
                tick();
            end
            bus.req_valid = '0;
            // Arbitration at cycle a sees requests pulsed at a-1 or earlier; done follows at a+l+2.
            cur = t0;
            rr = 0;
            for (int n = 0; n < nexp; n++) begin
                mn = 1 << 30;
                for (int i = 0; i < N; i++) if (rt[i] >= 0 && !served[i] && t0 + rt[i] < mn) mn = t0 + rt[i];
                a = (cur > mn + 1) ? cur : mn + 1;
                g = -1;
                for (int k = 0; k < N; k++) begin
                    int i = (rr + k) % N;
                    if (g < 0 && rt[i] >= 0 && !served[i] && t0 + rt[i] <= a - 1) g = i;
                end
                served[g] = 1'b1;
                exp_g[n] = g;
                exp_c[n] = a + l + 2;
                cur = exp_c[n] + 1;
                rr = (g + 1) % N;
            end
            wait_done(nexp, nexp * (l + 3) + 30);
            repeat (3) tick();
            n_tests++; if (dn_q.size() != nexp) begin n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", round, dn_q.size(), nexp); end
            for (int n = 0; n < nexp && n < dn_q.size(); n++) begin
                n_tests++;
                if (dn_q[n].d !== N'(1 << exp_g[n]) || dn_q[n].c != exp_c[n] || dn_q[n].r !== mul320(opa[exp_g[n]], opb[exp_g[n]])) begin
                    n_fail++;
                    $display("FAIL rand%0d_done%0d: got d=%b c=%0d want d=%b c=%0d", round, n, dn_q[n].d, dn_q[n].c - t0, N'(1 << exp_g[n]), exp_c[n] - t0);
                end
            end
            n_tests++; if (overrun_err !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL rand%0d_errs: got ovr=%b tmo=%b want 0 0", round, overrun_err, timeout_err); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_op_a = '0;
        bus.req_op_b = '0;
        test_reset();
        test_single();
        test_all_four();
        test_rr_wrap();
        test_timeout();
        test_reset_mid();
        test_overrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

endmodule
